// File: rtl/fu_result_buffer.sv
// fu_result_buffer: per-FU completion FIFO feeding one CDB request slot.
// Optional zero-latency bypass is enabled with `define FU_RESULT_BUFFER_BYPASS_EN.

package fu_result_buffer_pkg;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;
endpackage

module fu_result_buffer
    import fu_result_buffer_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1),
    parameter int unsigned STALL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  cdb_entry_t         fu_result,
    output logic               fu_ready,
    input  logic               squash,
    output cdb_entry_t         cdb_req,
    input  logic               cdb_gnt,
    output logic [CNT_W-1:0]   count,
    output logic [STALL_W-1:0] stall_count
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    cdb_entry_t         entry_q [DEPTH];
    cdb_entry_t         entry_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    cdb_entry_t head_entry_c;
    logic       bypass_c;
    logic       push_c;
    logic       pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Oldest buffered entry; valid only when something is held.
    always_comb begin
        head_entry_c = '0;
        if (count_q != '0) begin
            head_entry_c       = entry_q[head_q];
            head_entry_c.valid = 1'b1;
        end
    end

    // Request selection, push/pop qualification (squash suppresses both).
    always_comb begin
`ifdef FU_RESULT_BUFFER_BYPASS_EN
        bypass_c = reset && (count_q == '0) && fu_result.valid && !squash;
`else
        bypass_c = 1'b0;
`endif
        cdb_req  = bypass_c ? fu_result : head_entry_c;
        fu_ready = (count_q != FULL_CNT);
        pop_c    = head_entry_c.valid && cdb_gnt && !squash;
        push_c   = fu_result.valid && fu_ready && !squash && !(bypass_c && cdb_gnt);
    end

    // Next-state for FIFO storage, pointers, occupancy and stall counter.
    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;

        if (fu_result.valid && !fu_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end

        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_c) begin
                entry_d[tail_q] = fu_result;
                tail_d          = ptr_inc(tail_q);
            end
            if (pop_c) begin
                head_d = ptr_inc(head_q);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    assign count       = count_q;
    assign stall_count = stall_q;

endmodule
